// File: rtl/usbf_rx_pkt_fifo.sv
// usbf_rx_pkt_fifo: packet-aware receive FIFO behind the USB SIE receiver.
// Received bytes are stored speculatively and are committed or rewound when
// the packet ends. The read side is a first-word-fall-through stream in which
// every byte carries a flag marking the last byte of its packet.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync clear of everything)
//   accept_i                      endpoint armed, sampled on the first byte
//   rx_valid_i/rx_strb_i/rx_data_i receiver stream (strb=0 marks a ZLP)
//   rx_complete_i/rx_crc_err_i    end-of-packet pulse and its CRC status
//   rd_ready_i, rd_valid_o, rd_data_o, rd_last_o   FWFT read port
//   pkt_ok_o/pkt_drop_o/zlp_o     registered end-of-packet result pulses
//   overflow_o                    sticky, set when a packet is dropped for space
//   level_o                       committed byte count
// Build option: USBF_RX_FIFO_CRC_DROP_EN rewinds and drops CRC-errored packets;
// when it is undefined, CRC errors are ignored and such packets are committed.
module usbf_rx_pkt_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              accept_i,
    input  logic              rx_valid_i,
    input  logic              rx_strb_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_complete_i,
    input  logic              rx_crc_err_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [7:0]        rd_data_o,
    output logic              rd_last_o,
    output logic              pkt_ok_o,
    output logic              pkt_drop_o,
    output logic              zlp_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   level_o
);
    typedef enum logic [1:0] {S_IDLE, S_RX, S_DROP} state_t;
    state_t state_q, state_d;
    logic [ADDR_W:0] rd_ptr_q, cmt_ptr_q, wr_ptr_q, wr_ptr_d, cmt_ptr_d, wr_prev;
    logic [8:0] mem_q [DEPTH];
    logic rx_byte, full, crc_bad, pop, we, set_last;
    logic ok_d, drop_d, zlp_d, ovf_set;
    logic ok_q, drop_q, zlp_q, ovf_q;
`ifdef USBF_RX_FIFO_CRC_DROP_EN
    assign crc_bad = rx_crc_err_i;
`else
    logic unused_crc;
    assign unused_crc = rx_crc_err_i;
    assign crc_bad    = 1'b0;
`endif
    assign rx_byte    = rx_valid_i & rx_strb_i;
    // Fullness counts speculative bytes so a packet in flight cannot overrun unread data.
    assign full       = (wr_ptr_q - rd_ptr_q) == (ADDR_W+1)'(DEPTH);
    assign wr_prev    = wr_ptr_q - 1'b1;
    assign level_o    = cmt_ptr_q - rd_ptr_q;
    assign rd_valid_o = cmt_ptr_q != rd_ptr_q;
    assign pop        = rd_valid_o & rd_ready_i;
    assign rd_data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]][7:0];
    assign rd_last_o  = mem_q[rd_ptr_q[ADDR_W-1:0]][8];
    assign pkt_ok_o   = ok_q;
    assign pkt_drop_o = drop_q;
    assign zlp_o      = zlp_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= flush_i ? S_IDLE : state_d;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        we        = 1'b0;
        set_last  = 1'b0;
        ok_d      = 1'b0;
        drop_d    = 1'b0;
        zlp_d     = 1'b0;
        ovf_set   = 1'b0;
        case (state_q)
            S_IDLE:
                if (rx_complete_i) begin
                    zlp_d  = accept_i & ~crc_bad;
                    drop_d = ~(accept_i & ~crc_bad);
                end else if (rx_byte) begin
                    if (!accept_i)
                        state_d = S_DROP;
                    else if (full) begin
                        ovf_set = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = S_RX;
                    end
                end
            S_RX:
                if (rx_complete_i) begin
                    state_d = S_IDLE;
                    if (crc_bad) begin
                        wr_ptr_d = cmt_ptr_q;
                        drop_d   = 1'b1;
                    end else begin
                        set_last  = 1'b1;
                        cmt_ptr_d = wr_ptr_q;
                        ok_d      = 1'b1;
                    end
                end else if (rx_byte) begin
                    if (full) begin
                        ovf_set  = 1'b1;
                        wr_ptr_d = cmt_ptr_q;
                        state_d  = S_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            S_DROP:
                if (rx_complete_i) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            wr_ptr_q  <= '0;
            ok_q      <= 1'b0;
            drop_q    <= 1'b0;
            zlp_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            wr_ptr_q  <= '0;
            ok_q      <= 1'b0;
            drop_q    <= 1'b0;
            zlp_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q  <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cmt_ptr_q <= cmt_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ok_q      <= ok_d;
            drop_q    <= drop_d;
            zlp_q     <= zlp_d;
            ovf_q     <= ovf_q | ovf_set;
            if (we)
                mem_q[wr_ptr_q[ADDR_W-1:0]] <= {1'b0, rx_data_i};
            // The final byte is only known at rx_complete_i, so its flag is patched on commit.
            if (set_last)
                mem_q[wr_prev[ADDR_W-1:0]][8] <= 1'b1;
        end
endmodule

// File: tb/tb_usbf_rx_pkt_fifo.sv
// tb_usbf_rx_pkt_fifo: directed self-checking bench with a byte scoreboard.
module tb_usbf_rx_pkt_fifo;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic flush_i = 1'b0, accept_i = 1'b1;
    logic rx_valid_i = 1'b0, rx_strb_i = 1'b0, rx_complete_i = 1'b0, rx_crc_err_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic rd_ready_i = 1'b0;
    logic rd_valid_o, rd_last_o, pkt_ok_o, pkt_drop_o, zlp_o, overflow_o;
    logic [7:0] rd_data_o;
    logic [ADDR_W:0] level_o;
    int checks = 0, errors = 0;
    logic [8:0] sb [$];

    usbf_rx_pkt_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .accept_i(accept_i),
        .rx_valid_i(rx_valid_i), .rx_strb_i(rx_strb_i), .rx_data_i(rx_data_i),
        .rx_complete_i(rx_complete_i), .rx_crc_err_i(rx_crc_err_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o), .pkt_ok_o(pkt_ok_o), .pkt_drop_o(pkt_drop_o),
        .zlp_o(zlp_o), .overflow_o(overflow_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head();
        logic [8:0] exp;
        exp = sb.size() != 0 ? sb.pop_front() : 9'h1FF;
        check("head", {23'd0, rd_last_o, rd_data_o}, {23'd0, exp});
    endtask

    task automatic pulses(input logic ok, input logic drop, input logic zlp);
        check("pkt_ok", pkt_ok_o, ok);
        check("pkt_drop", pkt_drop_o, drop);
        check("zlp", zlp_o, zlp);
    endtask

    task automatic send_pkt(input int n, input logic [7:0] base, input logic [7:0] step, input bit commit);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i) * step;
            rx_valid_i = 1'b1;
            rx_strb_i  = 1'b1;
            rx_data_i  = d;
            if (commit) sb.push_back({i == n - 1, d});
            tick();
        end
        rx_valid_i = 1'b0;
        rx_strb_i  = 1'b0;
    endtask

    task automatic complete(input logic crc);
        rx_complete_i = 1'b1;
        rx_crc_err_i  = crc;
        tick();
        rx_complete_i = 1'b0;
        rx_crc_err_i  = 1'b0;
    endtask

    task automatic send_zlp();
        rx_valid_i = 1'b1;
        rx_strb_i  = 1'b0;
        tick();
        rx_valid_i = 1'b0;
        complete(1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("drain_level", 32'(level_o), 32'(n - i));
            check("drain_valid", rd_valid_o, 1'b1);
            check_head();
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
        end
        check("drain_empty", rd_valid_o, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", rd_valid_o, 1'b0);
        check("rst_data", rd_data_o, 8'h00);
        check("rst_last", rd_last_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_level", level_o, 0);
        pulses(0, 0, 0);
        rst_i = 1'b0;
        tick();

        // good 3-byte packet, and pops ignored while empty
        rd_ready_i = 1'b1;
        send_pkt(3, 8'h11, 8'h11, 1'b1);
        rd_ready_i = 1'b0;
        check("spec_level", level_o, 0);
        complete(1'b0);
        pulses(1, 0, 0);
        check("ok_level", level_o, 3);
        tick();
        pulses(0, 0, 0);
        drain(3);

        // CRC-errored packet
`ifdef USBF_RX_FIFO_CRC_DROP_EN
        send_pkt(3, 8'h11, 8'h11, 1'b0);
        complete(1'b1);
        pulses(0, 1, 0);
        check("crc_level", level_o, 0);
        check("crc_valid", rd_valid_o, 1'b0);
        tick();
`else
        send_pkt(3, 8'h11, 8'h11, 1'b1);
        complete(1'b1);
        pulses(1, 0, 0);
        check("crc_level", level_o, 3);
        tick();
        drain(3);
`endif

        // 70-byte overflow, then a normal 4-byte packet
        send_pkt(70, 8'h00, 8'h01, 1'b0);
        check("ovf_early", overflow_o, 1'b1);
        complete(1'b0);
        pulses(0, 1, 0);
        check("ovf_level", level_o, 0);
        check("ovf_valid", rd_valid_o, 1'b0);
        send_pkt(4, 8'hC0, 8'h01, 1'b1);
        complete(1'b0);
        pulses(1, 0, 0);
        check("ovf_sticky", overflow_o, 1'b1);
        drain(4);

        // exactly DEPTH bytes fits
        send_pkt(DEPTH, 8'h40, 8'h03, 1'b1);
        complete(1'b0);
        pulses(1, 0, 0);
        check("full_level", level_o, DEPTH);
        drain(DEPTH);

        // two back-to-back packets with a continuous reader
        fork
            begin
                send_pkt(5, 8'h50, 8'h01, 1'b1);
                complete(1'b0);
                send_pkt(5, 8'h60, 8'h01, 1'b1);
                complete(1'b0);
            end
            begin
                int got = 0;
                for (int c = 0; c < 100 && got < 10; c++) begin
                    @(posedge clk_i);
                    #1;
                    if (rd_valid_o) begin
                        check_head();
                        got++;
                        rd_ready_i = 1'b1;
                    end else
                        rd_ready_i = 1'b0;
                end
                tick();
                rd_ready_i = 1'b0;
                check("b2b_count", got, 10);
            end
        join
        check("b2b_level", level_o, 0);

        // ZLPs leave the level alone
        send_pkt(2, 8'h70, 8'h01, 1'b1);
        complete(1'b0);
        send_zlp();
        pulses(0, 0, 1);
        check("zlp_level", level_o, 2);
        accept_i = 1'b0;
        send_zlp();
        pulses(0, 1, 0);
        send_pkt(3, 8'h78, 8'h01, 1'b0);
        complete(1'b0);
        pulses(0, 1, 0);
        check("noacc_level", level_o, 2);
        accept_i = 1'b1;
        drain(2);

        // flush mid-packet with committed data and a coincident complete
        send_pkt(3, 8'h80, 8'h01, 1'b1);
        complete(1'b0);
        check("pre_flush", level_o, 3);
        send_pkt(2, 8'h90, 8'h01, 1'b0);
        flush_i = 1'b1;
        rx_complete_i = 1'b1;
        tick();
        flush_i = 1'b0;
        rx_complete_i = 1'b0;
        pulses(0, 0, 0);
        check("flush_level", level_o, 0);
        check("flush_valid", rd_valid_o, 1'b0);
        check("flush_ovf", overflow_o, 1'b0);
        check("flush_data", rd_data_o, 8'h00);
        sb.delete();
        tick();
        pulses(0, 0, 0);
        send_pkt(2, 8'hA0, 8'h01, 1'b1);
        complete(1'b0);
        pulses(1, 0, 0);
        drain(2);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
